// File: rtl/reg_map_cmd_pkg.sv
// Shared definitions for the switch-to-register-map command generator.
// Contents:
//   cmd_state_t  - command FSM state encoding
//   WR_ERR_OK    - completion status meaning "write accepted"
//   sw_reg_addr  - maps a switch index to its register address
package reg_map_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RETRY = 2'd3
    } cmd_state_t;

    localparam logic [1:0] WR_ERR_OK = 2'b00;

    // The caller truncates the result to its address width, which gives the
    // modulo-2^width wrap for free.
    function automatic logic [31:0] sw_reg_addr(input logic [31:0] base,
                                                input logic [31:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit synchroniser and debouncer for one switch input.
// Ports:
//   aclk         - clock
//   aresetn      - synchronous active-low reset; chain loads the raw input
//   sw_raw       - asynchronous switch input
//   sw_debounced - debounced level, follows sw_raw after a stable window
module sw_debounce #(
    parameter int DEBOUNCE_CTR_SIZE = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic sw_raw,
    output logic sw_debounced
);

    logic                         s1;
    logic                         s2;
    logic                         s3;
    logic [DEBOUNCE_CTR_SIZE-1:0] stable_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            // Start already settled so reset exit produces no spurious edge.
            s1           <= sw_raw;
            s2           <= sw_raw;
            s3           <= sw_raw;
            stable_cnt   <= '1;
            sw_debounced <= sw_raw;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
            s3 <= s2;
            if (s2 != s3) begin
                stable_cnt <= '0;
            end else if (stable_cnt != '1) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if ((stable_cnt == '1) && (s2 == s3)) begin
                sw_debounced <= s2;
            end
        end
    end

endmodule

// File: rtl/reg_map_sw_cmd_gen_n.sv
// Switch-to-register-map command generator for NUM_SW GPIO/DIP inputs.
// Each debounced edge marks the switch pending; a single-outstanding FSM
// writes {0, level} to SW_ADDR_BASE + index, retrying on error or timeout.
// Ports:
//   aclk, aresetn            - clock, synchronous active-low reset
//   gpio_dip_sw              - asynchronous switch inputs
//   sw_debounced             - debounced switch state
//   reg_map_wr_cmd           - one-cycle command strobe
//   reg_map_wr_addr/data/keep- command payload, held between commands
//   reg_map_wr_valid/err     - completion pulse and status (nonzero = error)
//   reg_map_wr_ready         - master can accept a command
//   busy                     - FSM active or any request pending
//   err_sticky, err_clear    - dropped-request flag and its clear
//
// state  | meaning
// IDLE   | wait for a pending switch and master ready, latch payload
// ISSUE  | strobe cmd, clear pending bit, arm timeout
// WAIT   | wait for completion; error/timeout -> RETRY or drop
// RETRY  | wait for master ready, re-issue latched payload
module reg_map_sw_cmd_gen_n
    import reg_map_cmd_pkg::*;
#(
    parameter int                          NUM_SW            = 8,
    parameter int                          DEBOUNCE_CTR_SIZE = 4,
    parameter int                          REG_ADDR_WIDTH    = 8,
    parameter int                          CORE_DATA_WIDTH   = 32,
    parameter logic [REG_ADDR_WIDTH-1:0]   SW_ADDR_BASE      = '0,
    parameter logic [NUM_SW-1:0]           SW_EN_MASK        = '1,
    parameter bit                          INIT_SYNC         = 1'b0,
    parameter int                          MAX_RETRY         = 3,
    parameter int                          WAIT_TIMEOUT      = 255
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_SW-1:0]          gpio_dip_sw,
    output logic [NUM_SW-1:0]          sw_debounced,
    output logic                       reg_map_wr_cmd,
    output logic [REG_ADDR_WIDTH-1:0]  reg_map_wr_addr,
    output logic [CORE_DATA_WIDTH-1:0] reg_map_wr_data,
    output logic [CORE_DATA_WIDTH-1:0] reg_map_wr_keep,
    input  logic                       reg_map_wr_valid,
    input  logic                       reg_map_wr_ready,
    input  logic [1:0]                 reg_map_wr_err,
    output logic                       busy,
    output logic                       err_sticky,
    input  logic                       err_clear
);

    localparam int IDX_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
    localparam int TMO_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    cmd_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  sel_idx;
    logic [RTY_W-1:0]  retry_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [NUM_SW-1:0] deb_prev;
    logic [NUM_SW-1:0] pending;
    logic [NUM_SW-1:0] pending_clr;
    logic [NUM_SW-1:0] sw_edge;
    logic              init_pend;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CTR_SIZE (DEBOUNCE_CTR_SIZE)
        ) u_deb (
            .aclk         (aclk),
            .aresetn      (aresetn),
            .sw_raw       (gpio_dip_sw[i]),
            .sw_debounced (sw_debounced[i])
        );
    end

    assign sw_edge = (sw_debounced ^ deb_prev) & SW_EN_MASK;
    assign busy    = (state != ST_IDLE) || (|pending);

    // Lowest pending index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        pending_clr = '0;
        if (state == ST_ISSUE) pending_clr[idx] = 1'b1;
    end

    // New edges are OR-ed in after the clear so a same-cycle edge survives;
    // the write for it picks up the level current at selection time.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            deb_prev  <= gpio_dip_sw;
            pending   <= '0;
            init_pend <= INIT_SYNC;
        end else begin
            deb_prev  <= sw_debounced;
            init_pend <= 1'b0;
            pending   <= (pending & ~pending_clr) | sw_edge |
                         (init_pend ? SW_EN_MASK : '0);
        end
    end

    // Timeout is a down-counter loaded in ISSUE; reaching zero in WAIT
    // means WAIT_TIMEOUT+1 WAIT cycles have elapsed.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            idx             <= '0;
            retry_cnt       <= '0;
            tmo_cnt         <= '0;
            reg_map_wr_cmd  <= 1'b0;
            reg_map_wr_addr <= '0;
            reg_map_wr_data <= '0;
            reg_map_wr_keep <= '0;
            err_sticky      <= 1'b0;
        end else begin
            reg_map_wr_cmd <= 1'b0;
            if (err_clear) err_sticky <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((|pending) && reg_map_wr_ready) begin
                        idx             <= sel_idx;
                        reg_map_wr_addr <= REG_ADDR_WIDTH'(sw_reg_addr(
                                               32'(SW_ADDR_BASE), 32'(sel_idx)));
                        reg_map_wr_data <= CORE_DATA_WIDTH'(sw_debounced[sel_idx]);
                        reg_map_wr_keep <= '1;
                        retry_cnt       <= '0;
                        reg_map_wr_cmd  <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= TMO_W'(WAIT_TIMEOUT);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (reg_map_wr_valid && (reg_map_wr_err == WR_ERR_OK)) begin
                        state <= ST_IDLE;
                    end else if (reg_map_wr_valid || (tmo_cnt == '0)) begin
                        if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_RETRY;
                        end else begin
                            err_sticky <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_RETRY: begin
                    if (reg_map_wr_ready) begin
                        reg_map_wr_cmd <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_map_sw_cmd_gen_n.sv
// Directed bench for reg_map_sw_cmd_gen_n. A second instance with INIT_SYNC=1
// and an automatic responder covers the reset-exit sync behaviour.
module tb_reg_map_sw_cmd_gen_n;

    logic        aclk;
    logic        aresetn;
    logic        aresetn2;
    logic [7:0]  gpio;
    logic [7:0]  sw_debounced;
    logic        reg_map_wr_cmd;
    logic [7:0]  reg_map_wr_addr;
    logic [31:0] reg_map_wr_data;
    logic [31:0] reg_map_wr_keep;
    logic        valid;
    logic        ready;
    logic [1:0]  err;
    logic        busy;
    logic        err_sticky;
    logic        err_clear;

    logic [7:0]  deb2;
    logic        cmd2;
    logic [7:0]  addr2;
    logic [31:0] data2;
    logic [31:0] keep2;
    logic        valid2;
    logic        cmd2_d;
    logic        busy2;
    logic        err2_sticky;

    logic [7:0]  q2_addr[$];
    logic [31:0] q2_data[$];
    logic [31:0] q2_keep[$];

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0]  c_addr;
    logic [31:0] c_data;
    logic [31:0] c_keep;
    int          c_cyc;

    reg_map_sw_cmd_gen_n #(
        .WAIT_TIMEOUT (15)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .gpio_dip_sw      (gpio),
        .sw_debounced     (sw_debounced),
        .reg_map_wr_cmd   (reg_map_wr_cmd),
        .reg_map_wr_addr  (reg_map_wr_addr),
        .reg_map_wr_data  (reg_map_wr_data),
        .reg_map_wr_keep  (reg_map_wr_keep),
        .reg_map_wr_valid (valid),
        .reg_map_wr_ready (ready),
        .reg_map_wr_err   (err),
        .busy             (busy),
        .err_sticky       (err_sticky),
        .err_clear        (err_clear)
    );

    reg_map_sw_cmd_gen_n #(
        .INIT_SYNC    (1'b1),
        .WAIT_TIMEOUT (15)
    ) dut_init (
        .aclk             (aclk),
        .aresetn          (aresetn2),
        .gpio_dip_sw      (gpio),
        .sw_debounced     (deb2),
        .reg_map_wr_cmd   (cmd2),
        .reg_map_wr_addr  (addr2),
        .reg_map_wr_data  (data2),
        .reg_map_wr_keep  (keep2),
        .reg_map_wr_valid (valid2),
        .reg_map_wr_ready (1'b1),
        .reg_map_wr_err   (2'b00),
        .busy             (busy2),
        .err_sticky       (err2_sticky),
        .err_clear        (1'b0)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc = cyc + 1;

    // Log the init instance's commands and answer each one OK in WAIT.
    initial begin
        valid2 = 1'b0;
        cmd2_d = 1'b0;
        forever begin
            @(negedge aclk);
            if (cmd2) begin
                q2_addr.push_back(addr2);
                q2_data.push_back(data2);
                q2_keep.push_back(keep2);
            end
            valid2 = cmd2_d;
            cmd2_d = cmd2;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cmd(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge aclk);
            if (reg_map_wr_cmd) begin
                seen   = 1'b1;
                c_addr = reg_map_wr_addr;
                c_data = reg_map_wr_data;
                c_keep = reg_map_wr_keep;
                c_cyc  = cyc;
                break;
            end
        end
    endtask

    task automatic expect_cmd(input string tag, input int budget,
                              input logic [7:0] a, input logic [31:0] d);
        bit seen;
        wait_cmd(budget, seen);
        chk({tag, "_seen"}, seen, 1'b1);
        chk({tag, "_addr"}, c_addr, a);
        chk({tag, "_data"}, c_data, d);
    endtask

    task automatic respond(input logic [1:0] e);
        @(negedge aclk);
        valid = 1'b1;
        err   = e;
        @(negedge aclk);
        valid = 1'b0;
        err   = 2'b00;
    endtask

    task automatic count_cmds(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge aclk);
            if (reg_map_wr_cmd) cnt++;
        end
    endtask

    initial begin
        int          n;
        int          t_edge;
        int          t_deb;
        int          t_prev;
        bit          seen;
        logic [7:0]  init_sw;

        init_sw   = 8'h05;
        gpio      = init_sw;
        ready     = 1'b1;
        valid     = 1'b0;
        err       = 2'b00;
        err_clear = 1'b0;
        aresetn   = 1'b0;
        aresetn2  = 1'b0;
        repeat (5) @(negedge aclk);

        chk("rst_cmd",  reg_map_wr_cmd, 1'b0);
        chk("rst_addr", reg_map_wr_addr, 8'h00);
        chk("rst_data", reg_map_wr_data, 32'h0);
        chk("rst_keep", reg_map_wr_keep, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err",  err_sticky, 1'b0);
        chk("rst_deb",  sw_debounced, 8'h05);

        aresetn  = 1'b1;
        aresetn2 = 1'b1;
        count_cmds(100, n);
        chk("nosync_cmds", n, 0);
        chk("nosync_deb",  sw_debounced, 8'h05);
        chk("nosync_busy", busy, 1'b0);

        chk("init_count", q2_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q2_addr.size()) begin
                chk($sformatf("init_addr%0d", i), q2_addr[i], 8'(i));
                chk($sformatf("init_data%0d", i), q2_data[i], 32'(init_sw[i]));
            end
        end
        if (q2_keep.size() > 0) chk("init_keep", q2_keep[0], 32'hFFFF_FFFF);
        aresetn2 = 1'b0;

        // sw[2] to 0 first so the glitch sequence can run 0 -> 1.
        gpio[2] = 1'b0;
        expect_cmd("sw2_fall", 40, 8'h02, 32'h0);
        respond(2'b00);

        gpio[2] = 1'b1; repeat (3) @(negedge aclk);
        gpio[2] = 1'b0; repeat (3) @(negedge aclk);
        gpio[2] = 1'b1; repeat (3) @(negedge aclk);
        gpio[2] = 1'b0; repeat (3) @(negedge aclk);
        gpio[2] = 1'b1;
        t_edge  = cyc;
        seen    = 1'b0;
        t_deb   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (sw_debounced[2]) begin
                seen  = 1'b1;
                t_deb = cyc;
                break;
            end
        end
        chk("sw2_deb_seen", seen, 1'b1);
        chk("sw2_deb_lat", t_deb - t_edge, 19);
        expect_cmd("sw2_rise", 10, 8'h02, 32'h1);
        chk("sw2_keep", c_keep, 32'hFFFF_FFFF);
        chk("sw2_cmd_lat", c_cyc - t_deb, 2);
        respond(2'b00);
        count_cmds(40, n);
        chk("sw2_single", n, 0);

        // Two switches change together: lower index first, one at a time.
        gpio[5] = 1'b1;
        gpio[1] = 1'b1;
        expect_cmd("pair_first", 40, 8'h01, 32'h1);
        count_cmds(10, n);
        chk("pair_hold", n, 0);
        respond(2'b00);
        expect_cmd("pair_second", 10, 8'h05, 32'h1);
        respond(2'b00);
        repeat (3) @(negedge aclk);
        chk("pair_idle_busy", busy, 1'b0);

        // Three errors then success: four identical commands, no sticky.
        gpio[0] = 1'b0;
        expect_cmd("rty_a0", 40, 8'h00, 32'h0);
        for (int r = 1; r <= 3; r++) begin
            respond(2'b01);
            expect_cmd($sformatf("rty_a%0d", r), 10, 8'h00, 32'h0);
        end
        respond(2'b00);
        count_cmds(20, n);
        chk("rty_ok_extra", n, 0);
        chk("rty_ok_sticky", err_sticky, 1'b0);

        // Four errors: request dropped, sticky set, then cleared.
        gpio[0] = 1'b1;
        expect_cmd("drop_a0", 40, 8'h00, 32'h1);
        for (int r = 1; r <= 3; r++) begin
            respond(2'b11);
            expect_cmd($sformatf("drop_a%0d", r), 10, 8'h00, 32'h1);
        end
        respond(2'b10);
        count_cmds(20, n);
        chk("drop_extra", n, 0);
        chk("drop_sticky", err_sticky, 1'b1);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        chk("drop_cleared", err_sticky, 1'b0);

        // No completion: re-issue every 18 cycles (ISSUE + 16 WAIT + RETRY).
        gpio[6] = 1'b1;
        expect_cmd("tmo_a0", 40, 8'h06, 32'h1);
        t_prev = c_cyc;
        for (int r = 1; r <= 3; r++) begin
            expect_cmd($sformatf("tmo_a%0d", r), 30, 8'h06, 32'h1);
            chk($sformatf("tmo_gap%0d", r), c_cyc - t_prev, 18);
            t_prev = c_cyc;
        end
        count_cmds(40, n);
        chk("tmo_extra", n, 0);
        chk("tmo_sticky", err_sticky, 1'b1);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;

        // Reset during WAIT aborts with nothing re-issued.
        gpio[7] = 1'b1;
        expect_cmd("rstw", 40, 8'h07, 32'h1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("rstw_cmd",  reg_map_wr_cmd, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_sticky", err_sticky, 1'b0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        count_cmds(60, n);
        chk("rstw_no_cmd", n, 0);
        chk("rstw_busy_after", busy, 1'b0);
        chk("rstw_deb", sw_debounced, 8'hE7);

        // sw[3] rises, then falls while its write is in WAIT: one extra write of 0.
        gpio[3] = 1'b1;
        t_edge  = cyc;
        repeat (17) @(negedge aclk);
        gpio[3] = 1'b0;
        expect_cmd("sw3_rise", 10, 8'h03, 32'h1);
        chk("sw3_rise_lat", c_cyc - t_edge, 21);
        while (cyc < t_edge + 36) @(negedge aclk);
        chk("sw3_deb_fell", sw_debounced[3], 1'b0);
        valid = 1'b1;
        @(negedge aclk);
        valid = 1'b0;
        expect_cmd("sw3_extra", 10, 8'h03, 32'h0);
        respond(2'b00);
        count_cmds(60, n);
        chk("sw3_no_more", n, 0);
        chk("sw3_sticky", err_sticky, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
